control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_pkg.sv | 100 ++++++++++
 rtl/control_alu_decode.sv | 30 +++
 rtl/control_unit.sv | 138 +++++++++++++
 tb/tb_control_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - opcode constants and control-field encodings for the decoder
package control_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_SLL    = 5'b00010;
  localparam logic [4:0] ALU_SLT    = 5'b00011;
  localparam logic [4:0] ALU_SLTU   = 5'b00100;
  localparam logic [4:0] ALU_XOR    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_OR     = 5'b01000;
  localparam logic [4:0] ALU_AND    = 5'b01001;
  localparam logic [4:0] ALU_MUL    = 5'b01010;
  localparam logic [4:0] ALU_MULH   = 5'b01011;
  localparam logic [4:0] ALU_MULHSU = 5'b01100;
  localparam logic [4:0] ALU_MULHU  = 5'b01101;
  localparam logic [4:0] ALU_DIV    = 5'b01110;
  localparam logic [4:0] ALU_DIVU   = 5'b01111;
  localparam logic [4:0] ALU_REM    = 5'b10000;
  localparam logic [4:0] ALU_REMU   = 5'b10001;
  localparam logic [4:0] ALU_FWD    = 5'b10010;

  localparam logic [2:0] IMM_B      = 3'b000;
  localparam logic [2:0] IMM_I_LOAD = 3'b001;
  localparam logic [2:0] IMM_I_ALU  = 3'b010;
  localparam logic [2:0] IMM_U      = 3'b011;
  localparam logic [2:0] IMM_J      = 3'b100;
  localparam logic [2:0] IMM_S      = 3'b101;

  localparam logic [1:0] BJ_NONE    = 2'b00;
  localparam logic [1:0] BJ_JUMP    = 2'b01;
  localparam logic [1:0] BJ_BRANCH  = 2'b10;

  // Coarse instruction class handed to the ALU-op decoder.
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_LUI    = 3'd1,
    CLS_ADD    = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_OP_IMM = 3'd4,
    CLS_OP     = 3'd5
  } op_class_e;

  typedef struct packed {
    logic [4:0] aluop;
    logic       reg_write_en;
    logic [2:0] imm_sel;
    logic       op1sel;
    logic       op2sel;
    logic       mem_write;
    logic       mem_read;
    logic       wb_sel;
    logic [1:0] branch_jump;
    logic       jal_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic [4:0] base_alu(input logic [2:0] funct3, input logic funct7_a);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_a ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [4:0] mext_alu(input logic [2:0] funct3);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      default: op = ALU_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_alu_decode.sv
// rtl/control_alu_decode.sv - maps instruction class and funct fields to an ALU operation
module control_alu_decode
  import control_pkg::*;
(
  input  logic [2:0] cls,
  input  logic [2:0] funct3,
  input  logic       funct7_a,
  input  logic       funct7_b,
  output logic [4:0] aluop
);

  always_comb begin
    aluop = ALU_ADD;
    case (cls)
      CLS_LUI:    aluop = ALU_FWD;
      CLS_BRANCH: aluop = ALU_SUB;
      CLS_OP_IMM: aluop = base_alu(funct3, funct7_a);
      CLS_OP: begin
        if (funct7_b)
          aluop = mext_alu(funct3);
        else if (funct3 == 3'b000 && funct7_a)
          aluop = ALU_SUB;
        else
          aluop = base_alu(funct3, funct7_a);
      end
      default:    aluop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - RV32 main decoder with stall hold register; M_EXT_EN enables MUL/DIV decode
module control_unit
  import control_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OPCODE,
  input  logic [2:0] funct3,
  input  logic       funct7_A,
  input  logic       funct7_B,
  input  logic       BUSY_WAIT,
  output logic [4:0] ALUOP,
  output logic       REG_WRITE_EN,
  output logic [2:0] IMM_SEL,
  output logic       OP1SEL,
  output logic       OP2SEL,
  output logic       MEM_WRITE,
  output logic       MEM_READ,
  output logic       WB_SEL,
  output logic [1:0] BRANCH_JUMP,
  output logic       JAL_SEL
);

  op_class_e  cls;
  logic       op_legal;
  logic [4:0] alu_code;
  ctrl_t      dec;
  ctrl_t      hold;
  ctrl_t      ctrl;

`ifdef M_EXT_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = ~funct7_B;
`endif

  always_comb begin
    cls = CLS_NONE;
    case (OPCODE)
      OPC_LUI:                                           cls = CLS_LUI;
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: cls = CLS_ADD;
      OPC_BRANCH:                                        cls = CLS_BRANCH;
      OPC_OP_IMM:                                        cls = CLS_OP_IMM;
      OPC_OP:                                            cls = op_legal ? CLS_OP : CLS_NONE;
      default:                                           cls = CLS_NONE;
    endcase
  end

  control_alu_decode u_alu_decode (
    .cls      (cls),
    .funct3   (funct3),
    .funct7_a (funct7_A),
    .funct7_b (funct7_B),
    .aluop    (alu_code)
  );

  always_comb begin
    dec = CTRL_NOP;
    case (OPCODE)
      OPC_LUI, OPC_AUIPC: begin
        dec.aluop        = alu_code;
        dec.reg_write_en = 1'b1;
        dec.imm_sel      = IMM_U;
      end
      OPC_JAL, OPC_JALR: begin
        dec.aluop        = alu_code;
        dec.reg_write_en = 1'b1;
        dec.imm_sel      = IMM_J;
        dec.branch_jump  = BJ_JUMP;
        dec.jal_sel      = 1'b1;
      end
      OPC_BRANCH: begin
        dec.aluop        = alu_code;
        dec.imm_sel      = IMM_B;
        dec.branch_jump  = BJ_BRANCH;
      end
      OPC_LOAD: begin
        dec.aluop        = alu_code;
        dec.reg_write_en = 1'b1;
        dec.imm_sel      = IMM_I_LOAD;
        dec.op1sel       = 1'b1;
        dec.mem_read     = 1'b1;
        dec.wb_sel       = 1'b1;
      end
      OPC_STORE: begin
        dec.aluop        = alu_code;
        dec.imm_sel      = IMM_S;
        dec.op1sel       = 1'b1;
        dec.mem_write    = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.aluop        = alu_code;
        dec.reg_write_en = 1'b1;
        dec.imm_sel      = IMM_I_ALU;
        dec.op1sel       = 1'b1;
      end
      OPC_OP: begin
        if (op_legal) begin
          dec.aluop        = alu_code;
          dec.reg_write_en = 1'b1;
          dec.imm_sel      = IMM_B;
          dec.op1sel       = 1'b1;
          dec.op2sel       = 1'b1;
        end
      end
      default: dec = CTRL_NOP;
    endcase
  end

  // Captures the live decode whenever the pipeline is moving, so a stall replays it.
  always_ff @(posedge CLK) begin
    if (RESET)
      hold <= CTRL_NOP;
    else if (!BUSY_WAIT)
      hold <= dec;
  end

  always_comb begin
    if (RESET)
      ctrl = CTRL_NOP;
    else if (BUSY_WAIT)
      ctrl = hold;
    else
      ctrl = dec;
  end

  assign ALUOP        = ctrl.aluop;
  assign REG_WRITE_EN = ctrl.reg_write_en;
  assign IMM_SEL      = ctrl.imm_sel;
  assign OP1SEL       = ctrl.op1sel;
  assign OP2SEL       = ctrl.op2sel;
  assign MEM_WRITE    = ctrl.mem_write;
  assign MEM_READ     = ctrl.mem_read;
  assign WB_SEL       = ctrl.wb_sel;
  assign BRANCH_JUMP  = ctrl.branch_jump;
  assign JAL_SEL      = ctrl.jal_sel;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit decode, stall hold and reset
module tb_control_unit;

  logic       CLK;
  logic       RESET;
  logic [6:0] OPCODE;
  logic [2:0] funct3;
  logic       funct7_A;
  logic       funct7_B;
  logic       BUSY_WAIT;
  logic [4:0] ALUOP;
  logic       REG_WRITE_EN;
  logic [2:0] IMM_SEL;
  logic       OP1SEL;
  logic       OP2SEL;
  logic       MEM_WRITE;
  logic       MEM_READ;
  logic       WB_SEL;
  logic [1:0] BRANCH_JUMP;
  logic       JAL_SEL;

  int vectors = 0;
  int errors  = 0;

  logic [16:0] sb[$];
  logic [16:0] m_hold;
  logic [16:0] got;
  logic [16:0] exp_w;

  control_unit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .OPCODE       (OPCODE),
    .funct3       (funct3),
    .funct7_A     (funct7_A),
    .funct7_B     (funct7_B),
    .BUSY_WAIT    (BUSY_WAIT),
    .ALUOP        (ALUOP),
    .REG_WRITE_EN (REG_WRITE_EN),
    .IMM_SEL      (IMM_SEL),
    .OP1SEL       (OP1SEL),
    .OP2SEL       (OP2SEL),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_READ     (MEM_READ),
    .WB_SEL       (WB_SEL),
    .BRANCH_JUMP  (BRANCH_JUMP),
    .JAL_SEL      (JAL_SEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Word layout: {aluop, rw, imm, op1, op2, mem_write, mem_read, wb, bj, jal}
  function automatic logic [16:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic f7a, input logic f7b);
    logic [4:0] a;
    logic       rw, o1, o2, mw, mr, wb, j;
    logic [2:0] imm;
    logic [1:0] bj;
    logic [4:0] base;
    {a, rw, imm, o1, o2, mw, mr, wb, bj, j} = '0;
    case (f3)
      3'd0: base = 5'd0;
      3'd1: base = 5'd2;
      3'd2: base = 5'd3;
      3'd3: base = 5'd4;
      3'd4: base = 5'd5;
      3'd5: base = f7a ? 5'd7 : 5'd6;
      3'd6: base = 5'd8;
      default: base = 5'd9;
    endcase
    case (opc)
      7'b0110111: begin a = 5'b10010; rw = 1; imm = 3'b011; end
      7'b0010111: begin rw = 1; imm = 3'b011; end
      7'b1101111, 7'b1100111: begin rw = 1; imm = 3'b100; bj = 2'b01; j = 1; end
      7'b1100011: begin a = 5'b00001; bj = 2'b10; end
      7'b0000011: begin rw = 1; imm = 3'b001; o1 = 1; mr = 1; wb = 1; end
      7'b0100011: begin imm = 3'b101; o1 = 1; mw = 1; end
      7'b0010011: begin rw = 1; imm = 3'b010; o1 = 1; a = base; end
      7'b0110011: begin
        if (!f7b) begin
          rw = 1; o1 = 1; o2 = 1;
          a = (f3 == 3'd0 && f7a) ? 5'd1 : base;
        end else begin
`ifdef M_EXT_EN
          rw = 1; o1 = 1; o2 = 1;
          a = 5'd10 + {2'b00, f3};
`endif
        end
      end
      default: ;
    endcase
    return {a, rw, imm, o1, o2, mw, mr, wb, bj, j};
  endfunction

  // Drives one vector at the falling edge and pushes what the outputs must show before the next rising edge.
  task automatic drive(input logic rst, input logic bw, input logic [6:0] opc,
                       input logic [2:0] f3, input logic f7a, input logic f7b);
    logic [16:0] live;
    @(negedge CLK);
    RESET = rst; BUSY_WAIT = bw; OPCODE = opc; funct3 = f3; funct7_A = f7a; funct7_B = f7b;
    live = model(opc, f3, f7a, f7b);
    if (rst)     sb.push_back(17'd0);
    else if (bw) sb.push_back(m_hold);
    else         sb.push_back(live);
    if (rst)     m_hold = 17'd0;
    else if (!bw) m_hold = live;
    #1;
    got = {ALUOP, REG_WRITE_EN, IMM_SEL, OP1SEL, OP2SEL, MEM_WRITE, MEM_READ, WB_SEL, BRANCH_JUMP, JAL_SEL};
  endtask

  task automatic test_reset;
    drive(1, 0, 7'b0110111, 3'd0, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL reset_lui got=%h exp=%h", got, exp_w); end
    drive(1, 0, 7'b0000011, 3'd0, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL reset_load got=%h exp=%h", got, exp_w); end
  endtask

  task automatic test_lui;
    drive(0, 0, 7'b0110111, 3'd5, 1, 1);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL lui got=%h exp=%h", got, exp_w); end
    vectors++;
    if ({ALUOP, REG_WRITE_EN, IMM_SEL, OP2SEL, BRANCH_JUMP, JAL_SEL} !== {5'b10010, 1'b1, 3'b011, 1'b0, 2'b00, 1'b0}) begin
      errors++; $display("FAIL lui_fields got=%b exp=%b", {ALUOP, REG_WRITE_EN, IMM_SEL, OP2SEL, BRANCH_JUMP, JAL_SEL}, 13'b1001010110000);
    end
    drive(0, 0, 7'b0010111, 3'd0, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL auipc got=%h exp=%h", got, exp_w); end
  endtask

  task automatic test_jumps;
    logic [6:0] opcs [2];
    opcs[0] = 7'b1101111; opcs[1] = 7'b1100111;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, opcs[i], 3'd0, 0, 0);
      exp_w = sb.pop_front(); vectors++;
      if (got !== exp_w) begin errors++; $display("FAIL jump%0d got=%h exp=%h", i, got, exp_w); end
      vectors++;
      if ({ALUOP, IMM_SEL, BRANCH_JUMP, JAL_SEL, REG_WRITE_EN} !== {5'b00000, 3'b100, 2'b01, 1'b1, 1'b1}) begin
        errors++; $display("FAIL jump%0d_fields got=%b exp=%b", i, {ALUOP, IMM_SEL, BRANCH_JUMP, JAL_SEL, REG_WRITE_EN}, 12'b000001000111);
      end
    end
  endtask

  task automatic test_mem_branch;
    for (int f = 0; f < 8; f += 3) begin
      drive(0, 0, 7'b1100011, f[2:0], 0, 0);
      exp_w = sb.pop_front(); vectors++;
      if (got !== exp_w) begin errors++; $display("FAIL branch_f%0d got=%h exp=%h", f, got, exp_w); end
    end
    vectors++;
    if ({ALUOP, REG_WRITE_EN, IMM_SEL, BRANCH_JUMP} !== {5'b00001, 1'b0, 3'b000, 2'b10}) begin
      errors++; $display("FAIL beq_fields got=%b exp=%b", {ALUOP, REG_WRITE_EN, IMM_SEL, BRANCH_JUMP}, 11'b00001000010);
    end
    drive(0, 0, 7'b0000011, 3'd0, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL lb got=%h exp=%h", got, exp_w); end
    vectors++;
    if ({MEM_READ, WB_SEL, OP1SEL, IMM_SEL, MEM_WRITE} !== {1'b1, 1'b1, 1'b1, 3'b001, 1'b0}) begin
      errors++; $display("FAIL lb_fields got=%b exp=%b", {MEM_READ, WB_SEL, OP1SEL, IMM_SEL, MEM_WRITE}, 7'b1110010);
    end
    drive(0, 0, 7'b0100011, 3'd0, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL sb got=%h exp=%h", got, exp_w); end
    vectors++;
    if ({MEM_WRITE, REG_WRITE_EN, IMM_SEL, MEM_READ} !== {1'b1, 1'b0, 3'b101, 1'b0}) begin
      errors++; $display("FAIL sb_fields got=%b exp=%b", {MEM_WRITE, REG_WRITE_EN, IMM_SEL, MEM_READ}, 6'b101010);
    end
  endtask

  task automatic test_alu_ops;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 4; k++) begin
        drive(0, 0, 7'b0010011, f[2:0], k[0], k[1]);
        exp_w = sb.pop_front(); vectors++;
        if (got !== exp_w) begin errors++; $display("FAIL opimm_f%0d_k%0d got=%h exp=%h", f, k, got, exp_w); end
        drive(0, 0, 7'b0110011, f[2:0], k[0], k[1]);
        exp_w = sb.pop_front(); vectors++;
        if (got !== exp_w) begin errors++; $display("FAIL op_f%0d_k%0d got=%h exp=%h", f, k, got, exp_w); end
      end
    end
    drive(0, 0, 7'b0110011, 3'd0, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if ({ALUOP, OP2SEL} !== {5'b00000, 1'b1}) begin errors++; $display("FAIL add_fields got=%b exp=%b", {ALUOP, OP2SEL}, 6'b000001); end
    drive(0, 0, 7'b0110011, 3'd0, 1, 0);
    exp_w = sb.pop_front(); vectors++;
    if (ALUOP !== 5'b00001) begin errors++; $display("FAIL sub_aluop got=%b exp=%b", ALUOP, 5'b00001); end
    drive(0, 0, 7'b0110011, 3'd0, 0, 1);
    exp_w = sb.pop_front(); vectors++;
`ifdef M_EXT_EN
    if ({ALUOP, REG_WRITE_EN} !== {5'b01010, 1'b1}) begin errors++; $display("FAIL mul_aluop got=%b exp=%b", {ALUOP, REG_WRITE_EN}, 6'b010101); end
`else
    if (got !== 17'd0) begin errors++; $display("FAIL mul_nop got=%h exp=%h", got, 17'd0); end
`endif
  endtask

  task automatic test_busy_hold;
    drive(0, 0, 7'b0010011, 3'd0, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL addi got=%h exp=%h", got, exp_w); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 7'b0100011, 3'd2, 0, 0);
      exp_w = sb.pop_front(); vectors++;
      if (got !== exp_w) begin errors++; $display("FAIL hold%0d got=%h exp=%h", i, got, exp_w); end
      vectors++;
      if ({IMM_SEL, REG_WRITE_EN, MEM_WRITE} !== {3'b010, 1'b1, 1'b0}) begin
        errors++; $display("FAIL hold%0d_fields got=%b exp=%b", i, {IMM_SEL, REG_WRITE_EN, MEM_WRITE}, 5'b01010);
      end
    end
    drive(0, 0, 7'b0100011, 3'd2, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL release got=%h exp=%h", got, exp_w); end
    drive(0, 0, 7'b1100011, 3'd1, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL b2b_branch got=%h exp=%h", got, exp_w); end
    drive(0, 1, 7'b0110111, 3'd0, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL b2b_hold got=%h exp=%h", got, exp_w); end
  endtask

  task automatic test_reset_busy;
    drive(0, 0, 7'b0000011, 3'd2, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL pre_load got=%h exp=%h", got, exp_w); end
    drive(1, 1, 7'b0000011, 3'd2, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL reset_busy got=%h exp=%h", got, exp_w); end
    drive(0, 1, 7'b0000011, 3'd2, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== 17'd0 || got !== exp_w) begin errors++; $display("FAIL hold_cleared got=%h exp=%h", got, exp_w); end
    drive(0, 0, 7'b1111111, 3'd0, 1, 1);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL undef_opc got=%h exp=%h", got, exp_w); end
    drive(0, 0, 7'b0000000, 3'd7, 0, 0);
    exp_w = sb.pop_front(); vectors++;
    if (got !== exp_w) begin errors++; $display("FAIL zero_opc got=%h exp=%h", got, exp_w); end
  endtask

  initial begin
    RESET = 1'b1; BUSY_WAIT = 1'b0; OPCODE = '0; funct3 = '0; funct7_A = 1'b0; funct7_B = 1'b0;
    m_hold = '0;
    test_reset();
    test_lui();
    test_jumps();
    test_mem_branch();
    test_alu_ops();
    test_busy_hold();
    test_reset_busy();
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
